// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and hazard scoreboard for the 32x32 register file.
// Optional feature: define WB_RR_EN for round-robin ALU/MEM arbitration (default: MEM > ALU).
module regfile_wb_sched #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rd,
  input  logic [ADDR_W-1:0]   iss_rs1,
  input  logic [ADDR_W-1:0]   iss_rs2,
  output logic                iss_stall,
  input  logic                alu_wb_valid,
  input  logic [ADDR_W-1:0]   alu_wb_rd,
  input  logic [DATA_W-1:0]   alu_wb_data,
  output logic                alu_wb_ready,
  input  logic                mem_wb_valid,
  input  logic [ADDR_W-1:0]   mem_wb_rd,
  input  logic [DATA_W-1:0]   mem_wb_data,
  output logic                mem_wb_ready,
  output logic                rf_load,
  output logic [ADDR_W-1:0]   rf_dest,
  output logic [DATA_W-1:0]   rf_in,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] eb;
  logic                alu_nz;
  logic                mem_nz;
  logic                grant_alu;
  logic                grant_mem;
  logic                grant;
  logic [ADDR_W-1:0]   wb_rd;
  logic [DATA_W-1:0]   wb_data;

  assign busy_vec = busy_q;

  // A register being written this cycle is readable through the regfile bypass.
  always_comb begin
    eb = busy_q;
    if (rf_load) eb[rf_dest] = 1'b0;
  end

  always_comb begin
    iss_stall = 1'b0;
    if (iss_valid) begin
      iss_stall = ((iss_rs1 != '0) && eb[iss_rs1]) ||
                  ((iss_rs2 != '0) && eb[iss_rs2]) ||
                  ((iss_rd  != '0) && eb[iss_rd]);
    end
  end

  assign alu_nz = alu_wb_valid && (alu_wb_rd != '0);
  assign mem_nz = mem_wb_valid && (mem_wb_rd != '0);

`ifdef WB_RR_EN
  typedef enum logic {PRI_ALU, PRI_MEM} rr_e;
  rr_e rr_q;
  rr_e rr_d;

  // Pointer only moves on contention, and always toward the loser.
  always_comb begin
    rr_d      = rr_q;
    grant_mem = mem_nz;
    grant_alu = alu_nz && !mem_nz;
    if (alu_nz && mem_nz) begin
      grant_mem = (rr_q == PRI_MEM);
      grant_alu = (rr_q == PRI_ALU);
      rr_d      = (rr_q == PRI_MEM) ? PRI_ALU : PRI_MEM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= PRI_ALU;
    else        rr_q <= rr_d;
  end
`else
  always_comb begin
    grant_mem = mem_nz;
    grant_alu = alu_nz && !mem_nz;
  end
`endif

  assign grant        = grant_alu || grant_mem;
  assign alu_wb_ready = alu_wb_valid && ((alu_wb_rd == '0) || grant_alu);
  assign mem_wb_ready = mem_wb_valid && ((mem_wb_rd == '0) || grant_mem);

  always_comb begin
    wb_rd   = alu_wb_rd;
    wb_data = alu_wb_data;
    if (grant_mem) begin
      wb_rd   = mem_wb_rd;
      wb_data = mem_wb_data;
    end
  end

  // Clear before set so a same-cycle re-issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_load) busy_d[rf_dest] = 1'b0;
    if (iss_valid && !iss_stall && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      rf_load <= 1'b0;
      rf_dest <= '0;
      rf_in   <= '0;
    end else begin
      busy_q  <= busy_d;
      rf_load <= grant;
      if (grant) begin
        rf_dest <= wb_rd;
        rf_in   <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Randomized scoreboard bench for regfile_wb_sched; honours WB_RR_EN when defined.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_stall;
  logic        alu_wb_valid, mem_wb_valid;
  logic [4:0]  alu_wb_rd, mem_wb_rd;
  logic [31:0] alu_wb_data, mem_wb_data;
  logic        alu_wb_ready, mem_wb_ready;
  logic        rf_load;
  logic [4:0]  rf_dest;
  logic [31:0] rf_in;
  logic [31:0] busy_vec;

  regfile_wb_sched #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  done    = 1'b0;

  // Reference state: pending-write set, the write landing this cycle, requester contents.
  bit [31:0]   m_busy;
  bit          m_lw;
  logic [4:0]  m_lwd;
  bit          a_v, b_v;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_d, b_d;
  bit          pref_mem;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [4:0] pick_rd();
    logic [4:0] r;
    r = 5'($urandom_range(1, 15));
    if ($urandom_range(0, 99) < 15) return 5'd0;
    if ($urandom_range(0, 99) < 60) begin
      for (int t = 0; t < 8; t++) begin
        r = 5'($urandom_range(1, 15));
        if (m_busy[r]) break;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_busy   = '0;
    m_lw     = 1'b0;
    m_lwd    = '0;
    a_v      = 1'b0;
    b_v      = 1'b0;
    pref_mem = 1'b0;
    exp_q.delete();
  endtask

  task automatic drive_idle();
    iss_valid    = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    alu_wb_valid = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
    mem_wb_valid = 1'b0; mem_wb_rd = '0; mem_wb_data = '0;
  endtask

  // Monitor: each rf_load must match the write granted exactly one cycle earlier.
  initial begin
    while (!done) begin
      @(negedge clk);
      if (rst_n && !done) begin
        if (rf_load) begin
          n_tests++;
          if (exp_q.size() == 0 || exp_q[0].cyc != cyc - 1) begin
            n_fail++;
            $display("FAIL wb_spurious cyc=%0d: got rf_load=1 dest=%0d expected rf_load=0", cyc, rf_dest);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (rf_dest !== e.dest || rf_in !== e.data) begin
              n_fail++;
              $display("FAIL wb_write cyc=%0d: got dest=%0d data=%h expected dest=%0d data=%h",
                       cyc, rf_dest, rf_in, e.dest, e.data);
            end
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc - 1) begin
          wr_t e;
          e = exp_q.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL wb_missing cyc=%0d: got rf_load=0 expected write dest=%0d", cyc, e.dest);
        end
      end
    end
  end

  initial begin
    bit         iv, exp_stall, a_nz, b_nz, win_a, win_b, exp_ar, exp_br;
    bit [31:0]  eb;
    logic [4:0] rd, rs1, rs2;
    int         next_rst;
    int         resets_done;

    rst_n = 1'b0;
    drive_idle();
    model_reset();
    next_rst    = 300;
    resets_done = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_load", {31'd0, rf_load}, 32'd0);
    check("reset_rf_dest", {27'd0, rf_dest}, 32'd0);
    check("reset_rf_in", rf_in, 32'd0);
    check("reset_busy", busy_vec, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      cyc++;

      if (i >= next_rst && m_lw && resets_done < 2) begin
        // Assert reset while a granted write is on the regfile port.
        check("pre_reset_rf_load", {31'd0, rf_load}, 32'd1);
        rst_n = 1'b0;
        drive_idle();
        #1;
        check("async_reset_rf_load", {31'd0, rf_load}, 32'd0);
        check("async_reset_busy", busy_vec, 32'd0);
        model_reset();
        resets_done++;
        next_rst += 500;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        continue;
      end

      if (!a_v && $urandom_range(0, 99) < 55) begin
        a_v = 1'b1; a_rd = pick_rd(); a_d = $urandom;
      end
      if (!b_v && $urandom_range(0, 99) < 55) begin
        b_v = 1'b1; b_rd = pick_rd(); b_d = $urandom;
      end
      iv  = ($urandom_range(0, 99) < 60);
      rd  = 5'($urandom_range(0, 15));
      rs1 = 5'($urandom_range(0, 15));
      rs2 = 5'($urandom_range(0, 15));
      if (m_lw && $urandom_range(0, 99) < 30) rd = m_lwd;

      iss_valid    = iv;  iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2;
      alu_wb_valid = a_v; alu_wb_rd = a_rd; alu_wb_data = a_d;
      mem_wb_valid = b_v; mem_wb_rd = b_rd; mem_wb_data = b_d;
      #2;

      eb = m_busy;
      if (m_lw) eb[m_lwd] = 1'b0;
      exp_stall = iv && ((rs1 != 0 && eb[rs1]) || (rs2 != 0 && eb[rs2]) || (rd != 0 && eb[rd]));

      a_nz = a_v && a_rd != 0;
      b_nz = b_v && b_rd != 0;
      win_b = b_nz;
      win_a = a_nz && !b_nz;
      if (a_nz && b_nz) begin
`ifdef WB_RR_EN
        win_b    = pref_mem;
        win_a    = !pref_mem;
        pref_mem = !pref_mem;
`else
        win_b = 1'b1;
        win_a = 1'b0;
`endif
      end
      exp_ar = a_v && (a_rd == 0 || win_a);
      exp_br = b_v && (b_rd == 0 || win_b);

      check("iss_stall", {31'd0, iss_stall}, {31'd0, exp_stall});
      check("busy_vec", busy_vec, m_busy);
      if (a_v) check("alu_wb_ready", {31'd0, alu_wb_ready}, {31'd0, exp_ar});
      if (b_v) check("mem_wb_ready", {31'd0, mem_wb_ready}, {31'd0, exp_br});

      if (win_a) exp_q.push_back('{cyc, a_rd, a_d});
      if (win_b) exp_q.push_back('{cyc, b_rd, b_d});

      if (m_lw) m_busy[m_lwd] = 1'b0;
      if (iv && !exp_stall && rd != 0) m_busy[rd] = 1'b1;
      m_lw  = win_a || win_b;
      m_lwd = win_b ? b_rd : a_rd;
      if (exp_ar) a_v = 1'b0;
      if (exp_br) b_v = 1'b0;
    end

    @(posedge clk);
    #1;
    cyc++;
    drive_idle();
    repeat (3) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("resets_exercised", resets_done, 2);
    check("queue_drained", exp_q.size(), 0);
    done = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
